// File: rtl/i2c_conf_pkg.sv
// Shared constants, frame layout and bus-level decode helpers for the I2C config sequencer.
package i2c_conf_pkg;

  // Sequencer states
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StShift = 3'd2;
  localparam logic [2:0] StAck   = 3'd3;
  localparam logic [2:0] StStop  = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  // Configuration word bit positions
  localparam int unsigned EN_BIT    = 0;
  localparam int unsigned GO_BIT    = 1;
  localparam int unsigned REG_LSB   = 8;
  localparam int unsigned DATA_LSB  = 16;
  localparam int unsigned SADDR_LSB = 24;

  localparam int unsigned FRAME_BYTES = 3;

  // Field order matches config word bits [30:8] so the latch is a plain copy
  typedef struct packed {
    logic [6:0] saddr;
    logic [7:0] data;
    logic [7:0] regaddr;
  } frame_t;

  // Byte sent in a given slot of the frame; slot 0 carries the write bit (0)
  function automatic logic [7:0] frame_byte(frame_t f, logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {f.saddr, 1'b0};
      2'd1:    b = f.regaddr;
      default: b = f.data;
    endcase
    return b;
  endfunction

  // SCL level for a state/quarter pair (1 = released)
  function automatic logic scl_level(logic [2:0] st, logic [1:0] qtr);
    logic l;
    case (st)
      StShift, StAck: l = qtr[1];
      StStop:         l = (qtr != 2'd0);
      default:        l = 1'b1;
    endcase
    return l;
  endfunction

  // SDA pull-down enable for a state/quarter pair; bit_v is the data bit in flight
  function automatic logic sda_drive(logic [2:0] st, logic [1:0] qtr, logic bit_v);
    logic d;
    case (st)
      StStart: d = qtr[1];
      StShift: d = ~bit_v;
      StStop:  d = ~qtr[1];
      default: d = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/i2c_conf_sequencer_if.sv
// Register-side config/status and pad-side SCL/SDA signals of the sequencer.
interface i2c_conf_sequencer_if;
  logic [31:0] data_system_i;
  logic        clr_conf;
  logic        busy_o;
  logic        nack_o;
  logic        scl_o;
  logic        sda_oe;
  logic        sda_i;

  modport master (
    input  data_system_i,
    input  sda_i,
    output clr_conf,
    output busy_o,
    output nack_o,
    output scl_o,
    output sda_oe
  );

  modport slave (
    output data_system_i,
    output sda_i,
    input  clr_conf,
    input  busy_o,
    input  nack_o,
    input  scl_o,
    input  sda_oe
  );
endinterface

// File: rtl/i2c_quarter_tick.sv
// Divider producing a one-cycle tick every CLK_DIV pclk cycles while run_i is high.
module i2c_quarter_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic pclk,
  input  logic reset,
  input  logic run_i,
  output logic tick_o
);

  localparam logic [15:0] LastCnt = 16'(CLK_DIV - 1);

  logic [15:0] cnt_q, cnt_d;

  assign tick_o = run_i && (cnt_q == LastCnt);

  // Count while running, wrap on the tick, hold at zero otherwise
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (!run_i || tick_o) begin
      cnt_d = 16'd0;
    end
  end

  // Counter register
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_conf_sequencer.sv
// Executes one 3-byte I2C write (slave addr, reg addr, data) per software go request.
module i2c_conf_sequencer
  import i2c_conf_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input logic                  pclk,
  input logic                  reset,
  i2c_conf_sequencer_if.master bus_io
);

  logic [2:0] state_q, state_d;
  logic [1:0] qtr_q, qtr_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] byte_q, byte_d;
  logic [7:0] sr_q, sr_d;
  frame_t     frame_q, frame_d;
  logic       nack_q, nack_d;
  logic       scl_q, scl_d;
  logic       sda_oe_q, sda_oe_d;

  logic run;
  logic tick;
  logic cfg_en, cfg_go;
  logic unused_cfg;

  assign cfg_en     = bus_io.data_system_i[EN_BIT];
  assign cfg_go     = bus_io.data_system_i[GO_BIT];
  assign unused_cfg = ^{bus_io.data_system_i[31], bus_io.data_system_i[7:2]};

  assign run = (state_q != StIdle) && (state_q != StDone);

  i2c_quarter_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .pclk  (pclk),
    .reset (reset),
    .run_i (run),
    .tick_o(tick)
  );

  // Frame sequencing: every phase advances one quarter per tick
  always_comb begin
    state_d = state_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sr_d    = sr_q;
    frame_d = frame_q;
    nack_d  = nack_q;

    case (state_q)
      StIdle: begin
        if (cfg_en && cfg_go) begin
          state_d = StStart;
          frame_d = frame_t'(bus_io.data_system_i[30:8]);
          nack_d  = 1'b0;
          qtr_d   = 2'd0;
          bit_d   = 3'd0;
          byte_d  = 2'd0;
          sr_d    = frame_byte(frame_t'(bus_io.data_system_i[30:8]), 2'd0);
        end
      end
      StStart: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            sr_d  = {sr_q[6:0], 1'b0};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = StAck;
            end
          end
        end
      end
      StAck: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          // Slave response is stable by the end of the first SCL-high quarter
          if (qtr_q == 2'd2) begin
            nack_d = nack_q | bus_io.sda_i;
          end
          if (qtr_q == 2'd3) begin
            if (nack_q || (byte_q == 2'(FRAME_BYTES - 1))) begin
              state_d = StStop;
            end else begin
              state_d = StShift;
              byte_d  = byte_q + 2'd1;
              sr_d    = frame_byte(frame_q, byte_q + 2'd1);
            end
          end
        end
      end
      StStop: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // Wait for the register to actually drop go before rearming
        if (!cfg_go) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    scl_d    = scl_level(state_d, qtr_d);
    sda_oe_d = sda_drive(state_d, qtr_d, sr_d[7]);
  end

  // State and registered pad levels (glitch-free SCL/SDA)
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      qtr_q    <= 2'd0;
      bit_q    <= 3'd0;
      byte_q   <= 2'd0;
      sr_q     <= 8'd0;
      frame_q  <= '0;
      nack_q   <= 1'b0;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      sr_q     <= sr_d;
      frame_q  <= frame_d;
      nack_q   <= nack_d;
      scl_q    <= scl_d;
      sda_oe_q <= sda_oe_d;
    end
  end

  assign bus_io.busy_o   = run;
  assign bus_io.clr_conf = (state_q == StDone);
  assign bus_io.nack_o   = nack_q;
  assign bus_io.scl_o    = scl_q;
  assign bus_io.sda_oe   = sda_oe_q;

endmodule

// File: tb/tb_i2c_conf_sequencer.sv
// Self-checking bench: behavioural I2C slave plus frame-level expectations.
module tb_i2c_conf_sequencer;

  localparam int unsigned CLK_DIV = 4;

  logic pclk  = 1'b0;
  logic reset = 1'b1;
  always #5 pclk = ~pclk;

  i2c_conf_sequencer_if bus ();

  logic slv_pull = 1'b0;
  assign bus.sda_i = ~(bus.sda_oe | slv_pull);

  i2c_conf_sequencer #(
    .CLK_DIV(CLK_DIV)
  ) dut (
    .pclk  (pclk),
    .reset (reset),
    .bus_io(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: decodes START/STOP and bytes from the wires, ACKs unless told otherwise
  int         nack_at   = 3;
  logic [7:0] got_bytes[$];
  int         stop_cnt  = 0;
  logic       prev_scl  = 1'b1;
  logic       prev_sda  = 1'b1;
  int         bits      = 0;
  int         nbyte     = 0;
  logic       in_frame  = 1'b0;
  logic [7:0] shreg     = 8'h00;

  always @(negedge pclk) begin
    logic scl_now, sda_now;
    scl_now = bus.scl_o;
    sda_now = bus.sda_i;
    if (!reset) begin
      in_frame = 1'b0;
      slv_pull = 1'b0;
      bits     = 0;
    end else if (prev_scl && scl_now && prev_sda && !sda_now) begin
      in_frame = 1'b1;
      bits     = 0;
      nbyte    = 0;
      got_bytes.delete();
    end else if (prev_scl && scl_now && !prev_sda && sda_now) begin
      if (in_frame) stop_cnt++;
      in_frame = 1'b0;
      bits     = 0;
      slv_pull = 1'b0;
    end else if (in_frame && !prev_scl && scl_now) begin
      if (bits < 8) begin
        shreg = {shreg[6:0], sda_now};
        bits++;
        if (bits == 8) got_bytes.push_back(shreg);
      end else begin
        bits = 9;
      end
    end else if (in_frame && prev_scl && !scl_now) begin
      if (bits == 8) begin
        slv_pull = (nbyte != nack_at);
      end else if (bits == 9) begin
        slv_pull = 1'b0;
        bits     = 0;
        nbyte++;
      end
    end
    prev_scl = scl_now;
    prev_sda = ~(bus.sda_oe | slv_pull);
  end

  // One frame: nk = byte index the slave NACKs (3 = none), hold = extra DONE cycles with go
  task automatic run_frame(input logic [6:0] sa, input logic [7:0] ra, input logic [7:0] da,
                           input int nk, input int hold, input bit mutate);
    int         nsent, cyc, stops0;
    logic [7:0] exp_b[3];
    exp_b[0] = {sa, 1'b0};
    exp_b[1] = ra;
    exp_b[2] = da;
    nsent    = (nk < 3) ? nk + 1 : 3;
    nack_at  = nk;
    stops0   = stop_cnt;
    bus.data_system_i = {1'b0, sa, da, ra, 6'b0, 2'b11};
    @(negedge pclk);
    check("busy_rise", 32'(bus.busy_o), 32'd1);
    cyc = 0;
    while (bus.busy_o && cyc < 5000) begin
      cyc++;
      if (mutate && cyc == 200) begin
        bus.data_system_i[23:16] = 8'h00;
        bus.data_system_i[0]     = 1'b0;
      end
      @(negedge pclk);
    end
    check("busy_len", 32'(cyc), 32'((8 + 36 * nsent) * CLK_DIV));
    check("clr_rise", 32'(bus.clr_conf), 32'd1);
    check("nack", 32'(bus.nack_o), (nk < 3) ? 32'd1 : 32'd0);
    check("stop_seen", 32'(stop_cnt - stops0), 32'd1);
    check("nbytes", 32'(got_bytes.size()), 32'(nsent));
    for (int i = 0; i < nsent && i < got_bytes.size(); i++) begin
      check($sformatf("byte%0d", i), 32'(got_bytes[i]), 32'(exp_b[i]));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge pclk);
      check("clr_hold", 32'(bus.clr_conf), 32'd1);
      check("busy_done", 32'(bus.busy_o), 32'd0);
    end
    bus.data_system_i[1] = 1'b0;
    @(negedge pclk);
    check("clr_fall", 32'(bus.clr_conf), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int viol;
    bus.data_system_i = 32'h0;
    #3 reset = 1'b0;
    #4;
    check("rst_scl", 32'(bus.scl_o), 32'd1);
    check("rst_sda", 32'(bus.sda_oe), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_clr", 32'(bus.clr_conf), 32'd0);
    check("rst_nack", 32'(bus.nack_o), 32'd0);
    repeat (2) @(negedge pclk);
    reset = 1'b1;
    @(negedge pclk);

    // Directed scenarios
    run_frame(7'h5A, 8'h10, 8'hC3, 3, 0, 1'b0);
    run_frame(7'h5A, 8'h10, 8'hC3, 0, 2, 1'b0);
    run_frame(7'h5A, 8'h10, 8'hC3, 3, 10, 1'b0);
    run_frame(7'h5A, 8'h10, 8'hC3, 3, 1, 1'b1);

    // go without enable must be ignored
    bus.data_system_i = {1'b0, 7'h33, 8'h5A, 8'h21, 6'b0, 2'b10};
    viol = 0;
    repeat (100) begin
      @(negedge pclk);
      if (bus.scl_o !== 1'b1 || bus.sda_oe !== 1'b0 || bus.busy_o !== 1'b0 ||
          bus.clr_conf !== 1'b0) viol++;
    end
    check("en_off_idle", 32'(viol), 32'd0);
    run_frame(7'h33, 8'h21, 8'h5A, 3, 0, 1'b0);

    // Reset during the second byte
    nack_at = 3;
    bus.data_system_i = {1'b0, 7'h11, 8'h22, 8'h33, 6'b0, 2'b11};
    repeat ((4 + 36 + 12) * CLK_DIV) @(negedge pclk);
    check("mid_busy", 32'(bus.busy_o), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("mrst_scl", 32'(bus.scl_o), 32'd1);
    check("mrst_sda", 32'(bus.sda_oe), 32'd0);
    check("mrst_busy", 32'(bus.busy_o), 32'd0);
    check("mrst_clr", 32'(bus.clr_conf), 32'd0);
    bus.data_system_i = 32'h0;
    repeat (3) @(negedge pclk);
    reset = 1'b1;
    @(negedge pclk);
    check("post_rst_idle", 32'(bus.busy_o), 32'd0);
    run_frame(7'h5A, 8'h10, 8'hC3, 3, 0, 1'b0);

    // Randomised frames
    for (int n = 0; n < 6; n++) begin
      run_frame(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_conf_sequencer.md
# i2c_conf_sequencer

Controller that consumes the 32-bit system configuration word held by the APB-mapped I2C system register and executes the requested I2C write on the bus. Software sets the go bit (bit 1); this block performs one 3-byte write frame (slave address, register address, data) as the I2C master, reports busy/NACK status, and drives `clr_conf` so the register clears the go bit. It sits between the register's `data_system_o` and the FPGA's SCL/SDA open-drain pads.

## Interface
- `CLK_DIV`, 4: pclk cycles per I2C quarter-bit. Legal range 2..65535.
- `pclk`  in  1  system clock (APB clock domain).
- `reset`  in  1  asynchronous, active-low reset.
- `data_system_i`  in  32  config word. [0] enable, [1] go, [7:2] reserved, [15:8] register address, [23:16] data byte, [30:24] 7-bit slave address, [31] reserved.
- `clr_conf`  out  1  request to clear go bit. Held until go reads back 0.
- `busy_o`  out  1  frame in progress (START through STOP).
- `nack_o`  out  1  sticky. Last frame received a NACK. Cleared when the next frame starts.
- `scl_o`  out  1  SCL level (1 = released/high, 0 = driven low).
- `sda_oe`  out  1  SDA pull-down enable (1 = drive low, 0 = release).
- `sda_i`  in  1  SDA pad input. Already synchronised externally.

## Operation
- Reset values: `clr_conf`=0, `busy_o`=0, `nack_o`=0, `scl_o`=1, `sda_oe`=0, state IDLE, divider 0.
- IDLE: when `data_system_i[0]`=1 and `data_system_i[1]`=1, latch [30:8] into a frame register and go to START. `nack_o` clears on the same edge. If go=1 with enable=0, the block stays in IDLE, does nothing, and leaves go set.
- START: SDA falls while SCL is high.
- SHIFT: bytes are sent MSB first in this order: {slave_addr, 0 (write)}, reg_addr, data. After each group of 8 bits the block enters ACK.
- ACK: SDA released. `sda_i` sampled. 0 means ACK: go to the next byte, or to STOP after the third byte. 1 means NACK: set `nack_o` and go straight to STOP. Remaining bytes are skipped.
- STOP: SDA rises while SCL is high. Then go to DONE.
- DONE: `clr_conf`=1 and `busy_o`=0. Stay until `data_system_i[1]`=0, then return to IDLE with `clr_conf`=0. This handshake covers the register ignoring `clr_conf` during an APB access.
- Changes to `data_system_i` during a frame have no effect, because fields are latched at start. Dropping enable mid-frame does not abort the frame.
- No clock stretching and no arbitration. `scl_o` is driven open-drain by the pad wrapper.

## Timing
- Divider: counts 0..CLK_DIV-1 while not IDLE/DONE and produces a one-cycle quarter tick at CLK_DIV-1. It is held at 0 in IDLE.
- Each bit is 4 quarters:
  - q0: SCL low, update SDA.
  - q1: SCL low.
  - q2: SCL high.
  - q3: SCL high. ACK is sampled on the tick that ends q2.
- START is 4 quarters: SDA released with SCL high for 2, then SDA low with SCL high for 2.
- STOP is 4 quarters:
  - q0: SCL low, SDA low.
  - q1: SCL high, SDA low.
  - q2–q3: SCL high, SDA released.
- `busy_o` rises 1 cycle after go is seen (the latch edge).
- Full ACKed frame: 4 + 27×4 + 4 = 116 quarters = 116×CLK_DIV cycles. `busy_o` falls and `clr_conf` rises on the same edge.
- NACK on the address byte: 4 + 9×4 + 4 = 44 quarters.
- `clr_conf` falls on the first edge after go reads 0. IDLE can accept a new go no earlier than the following cycle.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). The bus is released, so SDA high with SCL high looks like an idle bus. No STOP is generated.

## Structure
- Package `i2c_conf_pkg`:
  - state enum {IDLE, START, SHIFT, ACK, STOP, DONE}
  - config bit positions (EN_BIT=0, GO_BIT=1, REG_LSB=8, DATA_LSB=16, SADDR_LSB=24)
  - FRAME_BYTES=3
- Sub-module `i2c_quarter_tick`: the CLK_DIV counter, with inputs run/pclk/reset and output tick.
- Top level: FSM, 2-bit quarter counter, 3-bit bit counter, 2-bit byte counter, 8-bit shift register.

## Test plan
- Reset, then config 0x5A_C3_10_03 (slave 0x5A, reg 0x10, data 0xC3, en+go) with CLK_DIV=4 and the slave ACKing every byte. Required response:
  - SDA bytes observed are 0xB4, 0x10, 0xC3.
  - `busy_o` stays high for 464 cycles.
  - `clr_conf` then rises and `nack_o`=0.
- Slave NACKs the address byte. Required response: `nack_o`=1, STOP follows immediately, and the frame lasts 176 cycles (44 quarters).
- go=1 with enable=0 for 100 cycles. Required response: SCL and SDA stay released, `busy_o`=0, `clr_conf`=0. Then set enable; the frame starts 1 cycle later.
- In DONE, hold go=1 for 10 extra cycles. Required response: `clr_conf` stays high throughout and falls 1 cycle after go drops to 0.
- Change `data_system_i[23:16]` to 0x00 mid-frame. Required response: the data byte transmitted is still 0xC3.
- Assert reset during the second byte. Required response: `scl_o`=1, `sda_oe`=0, `busy_o`=0 within the same cycle. After reset releases, a new go produces a full, correct frame.
